// File: rtl/fifo_pool_reader_if.sv
// Pool FIFO read port plus the active-low LocalLink-style TX stream of fifo_pool_reader.
// master = the reader block; slave = the FIFO / Aurora TX side.
interface fifo_pool_reader_if;
  logic        fifo_rd_en;
  logic        fifo_rd_empty;
  logic [31:0] fifo_rd_data;
  logic [31:0] tx_d;
  logic        tx_src_rdy_n;
  logic        tx_dst_rdy_n;
  logic        tx_sof_n;
  logic        tx_eof_n;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_empty,
    input  fifo_rd_data,
    output tx_d,
    output tx_src_rdy_n,
    input  tx_dst_rdy_n,
    output tx_sof_n,
    output tx_eof_n
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_empty,
    output fifo_rd_data,
    input  tx_d,
    input  tx_src_rdy_n,
    output tx_dst_rdy_n,
    input  tx_sof_n,
    input  tx_eof_n
  );
endinterface

// File: rtl/fifo_pool_reader.sv
// Frames pool FIFO words into PKT_WORDS-word TX packets; first beat 2 cycles after FIFO non-empty, 2-entry skid absorbs sink stalls.
// FIFO_POOL_RD_HDR_EN: each frame starts with a {16'hA5C3, pkt_count[15:0]} SOF header beat.
module fifo_pool_reader #(
  parameter int PKT_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  fifo_pool_reader_if.master        bus,
  output logic [31:0]               pkt_count,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);
  localparam logic [CNT_W:0]   RD_LIMIT  = (CNT_W + 1)'(PKT_WORDS);

  state_t         state_q, state_d;
  logic           run_q;
  logic [1:0]     occ_q, occ_d;
  logic           inflight_q, inflight_d;
  logic [31:0]    d0_q, d0_d;
  logic [31:0]    d1_q, d1_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W:0] rdcnt_q, rdcnt_d;
  logic [31:0]    pkt_q, pkt_d;
  logic           busy_q, busy_d;

  logic           hdr_vld, pay_vld, hdr_beat, pay_beat, fetch_ok, rd_en;
  logic [1:0]     level;

  always_comb begin
    hdr_vld = 1'b0;
`ifdef FIFO_POOL_RD_HDR_EN
    hdr_vld = (state_q == HDR);
`endif
    pay_vld  = (state_q == SEND) && (occ_q != 2'd0);
    pay_beat = pay_vld && !bus.tx_dst_rdy_n;
    hdr_beat = hdr_vld && !bus.tx_dst_rdy_n;
    fetch_ok = (state_q == SEND) || (state_q == HDR) || ((state_q == IDLE) && enable);
    // Room is judged after this cycle's pop so a ready sink sees one word per cycle.
    level    = occ_q + {1'b0, inflight_q} - {1'b0, pay_beat};
    rd_en    = run_q && !bus.fifo_rd_empty && fetch_ok && (level < 2'd2) && (rdcnt_q < RD_LIMIT);

    state_d    = state_q;
    occ_d      = level;
    inflight_d = rd_en;
    rdcnt_d    = rdcnt_q + {{CNT_W{1'b0}}, rd_en};
    wcnt_d     = wcnt_q;
    pkt_d      = pkt_q;
    busy_d     = busy_q;

    d0_d = d0_q;
    d1_d = d1_q;
    if (pay_beat) begin
      d0_d = d1_q;
    end
    if (inflight_q) begin
      if ((occ_q - {1'b0, pay_beat}) == 2'd0) begin
        d0_d = bus.fifo_rd_data;
      end else begin
        d1_d = bus.fifo_rd_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (rd_en) begin
`ifdef FIFO_POOL_RD_HDR_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
      HDR: begin
        if (hdr_beat) begin
          state_d = SEND;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (pay_beat) begin
          wcnt_d = wcnt_q + CNT_W'(1);
`ifndef FIFO_POOL_RD_HDR_EN
          if (wcnt_q == '0) begin
            busy_d = 1'b1;
          end
`endif
          if (wcnt_q == LAST_WORD) begin
            wcnt_d  = '0;
            rdcnt_d = '0;
            pkt_d   = pkt_q + 32'd1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // run_q holds off the first read for one cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      wcnt_q     <= '0;
      rdcnt_q    <= '0;
      pkt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      wcnt_q     <= wcnt_d;
      rdcnt_q    <= rdcnt_d;
      pkt_q      <= pkt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.tx_src_rdy_n = !(hdr_vld || pay_vld);
  assign bus.tx_d         = hdr_vld ? {16'hA5C3, pkt_q[15:0]} : d0_q;
`ifdef FIFO_POOL_RD_HDR_EN
  assign bus.tx_sof_n     = !hdr_vld;
`else
  assign bus.tx_sof_n     = !(pay_vld && (wcnt_q == '0));
`endif
  assign bus.tx_eof_n     = !(pay_vld && (wcnt_q == LAST_WORD));
  assign pkt_count        = pkt_q;
  assign busy             = busy_q;

endmodule

// File: doc/fifo_pool_reader.md
Name: fifo_pool_reader

Overview:
- Drains the 32-bit pool FIFO from its read side: fifo_rd_en / fifo_rd_empty / fifo_rd_data, standard (non-FWFT) read, 1-cycle latency.
- Frames the words into fixed-length packets on an active-low LocalLink-style TX stream toward the Aurora TX user interface.
- Absorbs the FIFO read latency and downstream back-pressure with a 2-entry skid buffer.
- Never drops or duplicates a word.

Parameters:
- PKT_WORDS, 256: payload words per packet, legal range 2..65535.
- CNT_W, 16: width of the payload word counter; must satisfy 2^CNT_W >= PKT_WORDS.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = allowed to start new packets; sampled only at packet boundaries.
- fifo_rd_en  out  1  pool FIFO read strobe.
- fifo_rd_empty  in  1  pool FIFO empty flag.
- fifo_rd_data  in  32  pool FIFO data, valid the cycle after fifo_rd_en.
- tx_d  out  32  stream data.
- tx_src_rdy_n  out  1  active-low: tx_d valid.
- tx_dst_rdy_n  in  1  active-low: sink accepts.
- tx_sof_n  out  1  active-low start of frame.
- tx_eof_n  out  1  active-low end of frame.
- pkt_count  out  32  packets fully sent, wraps 0xFFFFFFFF -> 0.
- busy  out  1  1 while inside a packet (SOF sent, EOF not yet sent).

Behaviour:
- Transfer: a beat completes on a cycle with tx_src_rdy_n=0 and tx_dst_rdy_n=0.
- Reset (rst_n=0 at a clock edge) forces:
  - fifo_rd_en=0, tx_src_rdy_n=1, tx_sof_n=1, tx_eof_n=1, tx_d=0, pkt_count=0, busy=0.
  - skid buffer emptied, in-flight flag cleared, word counter=0, FSM=IDLE.
  - Words already read from the FIFO are discarded. The pool FIFO is expected to be reset together with this block.
- Read issue:
  - fifo_rd_en = !fifo_rd_empty && fetch_allowed && (occupancy + in_flight) < 2.
  - in_flight is a 1-bit register set by fifo_rd_en.
  - fifo_rd_data is captured into the skid buffer the cycle after fifo_rd_en.
  - fetch_allowed = state==SEND || (state==IDLE && enable).
  - Total reads per packet never exceed PKT_WORDS, so no word of the next packet is read while the current packet is closing.
  - Registered outputs are driven from the skid head. Minimum latency, FIFO non-empty to first beat: 2 cycles (rd_en, capture; beat valid on the 3rd edge).
- FSM states:
  - IDLE: start reading when enable=1 and FIFO non-empty. Go to SEND.
  - SEND: stream words. word counter increments on each completed beat.
    - tx_sof_n=0 on the beat with counter==0.
    - tx_eof_n=0 on the beat with counter==PKT_WORDS-1.
    - On the EOF beat: counter <- 0, pkt_count <- pkt_count+1, go to IDLE.
  - HDR: exists only with FIFO_POOL_RD_HDR_EN; see Optional Feature.
- Throughput and stalls:
  - 1 word/cycle sustained when FIFO non-empty and sink ready.
  - FIFO empty mid-packet: tx_src_rdy_n=1 (gap); the packet resumes when data returns. A packet is never truncated.
  - tx_dst_rdy_n=1: tx_d, tx_sof_n and tx_eof_n hold stable; at most one extra word is read into the skid.
- enable deasserted mid-packet: the current packet completes; no new packet starts.
- Simultaneous capture and beat: both apply in the same cycle; occupancy unchanged.
- busy=1 from the SOF beat through the cycle before the EOF beat completes.

Optional Feature:
- Macro: FIFO_POOL_RD_HDR_EN.
- Defined:
  - Each packet is preceded by one header beat {16'hA5C3, pkt_count[15:0]}, carrying tx_sof_n=0.
  - Payload beats carry no SOF. EOF stays on the last payload beat. Frame length = PKT_WORDS+1.
  - FSM: IDLE -> HDR -> SEND. HDR waits for sink ready and issues the first FIFO read in parallel.
- Undefined: no HDR state; SOF on the first payload word; frame length = PKT_WORDS.

Test Plan:
- Reset: rst_n=0 for 3 cycles with FIFO non-empty -> fifo_rd_en=0, tx_src_rdy_n=1, pkt_count=0 throughout and 1 cycle after release.
- Streaming: PKT_WORDS=4, preload 8 words 0x1..0x8, sink always ready -> two frames {1,2,3,4} and {5,6,7,8}; SOF on 1 and 5, EOF on 4 and 8; no gaps; pkt_count=2.
- Back-pressure: tx_dst_rdy_n toggled 1-0-1-0 during a frame -> tx_d held stable while stalled; sequence intact; at most 2 FIFO reads ahead of the sink.
- Underflow: preload 2 words with PKT_WORDS=4, add 2 more words 10 cycles later -> src_rdy gap, then EOF on the 4th word; no duplicate or dropped data.
- Enable drop: enable=0 after the SOF of packet 1 with 12 words queued -> packet 1 completes, no SOF follows, FIFO holds 8 words.
- HDR_EN: with the macro defined, pkt_count=0x0001FFFF -> header 0xA5C3FFFF with SOF, then 4 payload words, EOF on the last.
